multiple_operand_accumulator: RTL and testbench
===============================================

MULTIPLE_OPERAND_ACCUMULATOR -- requirements
Module: multiple_operand_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 SHALL have parameter MAX_OPS, default 16, giving the maximum operands per group (power of two, >= 2).
REQ-003 SHALL have localparam OUT_W = N + $clog2(MAX_OPS), giving the result width; CW = $clog2(MAX_OPS+1), giving the count width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-007 SHALL have port in_ready, output, 1 bit: operand beat can be accepted.
REQ-008 SHALL have port in_data, input, N bits: unsigned operand.
REQ-009 SHALL have port in_last, input, 1 bit: final operand of the group.
REQ-010 SHALL have port out_valid, output, 1 bit: result available.
REQ-011 SHALL have port out_ready, input, 1 bit: result consumed.
REQ-012 SHALL have port out_sum, output, OUT_W bits: exact unsigned sum of the group.
REQ-013 SHALL have port out_count, output, CW bits: number of operands in the group.

Function
REQ-014 SHALL treat a beat as accepted on a rising edge where in_valid && in_ready.
REQ-015 SHALL hold the running total in carry-save form: registers s and c, both OUT_W bits.
REQ-016 On each accepted beat, SHALL apply one 3:2 CSA step: s <= s ^ c ^ {0,in_data}; c <= majority(s, c, {0,in_data}) << 1. There SHALL be no carry-propagate adder in the accumulate path.
REQ-017 SHALL have FSM states ACCUM, RESOLVE and HOLD; the reset state is ACCUM.
REQ-018 In ACCUM, in_ready = 1. An accepted beat increments the count. ACCUM goes to RESOLVE when the beat has in_last=1, or when the count reaches MAX_OPS.
REQ-019 In RESOLVE, in_ready = 0. SHALL do a single CPA add, out_sum <= s + c, latch out_count, and go to HOLD.
REQ-020 In HOLD, out_valid = 1 and in_ready = 0. out_sum and out_count SHALL stay stable until out_ready=1. On that edge: go to ACCUM, clear s, c and count, and deassert out_valid.
REQ-021 Latency: out_valid SHALL assert 2 cycles after the edge that accepts the closing beat. Back-to-back throughput is one group per (ops + 2) cycles when out_ready is held at 1.
REQ-022 A group whose MAX_OPS-th beat has in_last=0 SHALL close anyway. The next accepted beat starts a new group.
REQ-023 in_data and in_last SHALL be ignored whenever in_ready=0.
REQ-024 The result SHALL never overflow: MAX_OPS*(2^N-1) < 2^OUT_W.

Reset
REQ-025 On rst=1 at a clock edge, SHALL set state to ACCUM; s, c, count, out_sum and out_count to 0; and out_valid to 0. This applies in any state, including mid-group and in HOLD.
REQ-026 While rst=1, in_ready SHALL be 0. A partially accumulated group is discarded by reset.

Configuration
REQ-027 Macro MOA_TRUNC_FLAG_EN, when defined, SHALL add the output port out_trunc (1 bit). out_trunc is set in RESOLVE to 1 if the group closed by REQ-022 without in_last, else 0. It is held with out_sum, and is 0 at reset.
REQ-028 Without MOA_TRUNC_FLAG_EN, out_trunc SHALL be absent and forced closure SHALL be silent. All other behaviour is identical.

Verification (N=4, MAX_OPS=16, OUT_W=8)
REQ-029 Operands 15,15,15,15 with last on the 4th, out_ready=1 -> out_sum=60, out_count=4; out_valid 2 cycles after the last accept, asserted for 1 cycle.
REQ-030 A single operand 9 with last=1 -> out_sum=9, out_count=1; in_ready=0 for exactly 2 cycles before ACCUM resumes.
REQ-031 16 operands of 15 with last=0 throughout, then 3 with last=1 -> first result out_sum=240, out_count=16, out_trunc=1 (when enabled); second result out_sum=3, out_count=1, out_trunc=0.
REQ-032 Group 7,8 with last, out_ready=0 for 5 cycles -> out_valid and out_sum=15 held stable; in_ready=0 throughout; the group is released on the first out_ready=1 edge.
REQ-033 Beats 5,6,7 then rst=1 for 1 cycle, then group 1,2 with last -> all outputs 0 after reset; then out_sum=3, out_count=2.
REQ-034 Random groups of 1..20 beats with random valid/ready gaps -> out_sum matches the reference sum of each (≤16-beat) chunk; no beat is lost or duplicated.

Source files
------------

// File: rtl/multiple_operand_accumulator.sv
// Operand-group accumulator: carry-save running total, one carry-propagate add per group.
// Optional MOA_TRUNC_FLAG_EN adds out_trunc, flagging groups closed at MAX_OPS without in_last.
module multiple_operand_accumulator #(
  parameter int N = 4,
  parameter int MAX_OPS = 16,
  localparam int OUT_W = N + $clog2(MAX_OPS),
  localparam int CW = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_sum,
  output logic [CW-1:0]    out_count
`ifdef MOA_TRUNC_FLAG_EN
  ,
  output logic             out_trunc
`endif
);

  // Handshake: a beat moves on a rising edge where valid && ready (both sides).
  // out_valid holds, with out_sum/out_count stable, until the edge with out_ready=1.
  typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

  state_t           state;
  logic [OUT_W-1:0] s;
  logic [OUT_W-1:0] c;
  logic [OUT_W-1:0] d_ext;
  logic [OUT_W-1:0] s_next;
  logic [OUT_W-1:0] c_next;
  logic [CW-1:0]    count;
  logic             accept;
  logic             closing;
`ifdef MOA_TRUNC_FLAG_EN
  logic             forced;
`endif

  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;
  assign d_ext    = {{(OUT_W-N){1'b0}}, in_data};

  // 3:2 compression only; the carry chain is deferred to RESOLVE.
  assign s_next  = s ^ c ^ d_ext;
  assign c_next  = ((s & c) | (s & d_ext) | (c & d_ext)) << 1;
  assign closing = in_last || (count == CW'(MAX_OPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      s         <= '0;
      c         <= '0;
      count     <= '0;
      out_sum   <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
`ifdef MOA_TRUNC_FLAG_EN
      forced    <= 1'b0;
      out_trunc <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s     <= s_next;
            c     <= c_next;
            count <= count + 1'b1;
            if (closing) begin
              state <= RESOLVE;
`ifdef MOA_TRUNC_FLAG_EN
              forced <= !in_last;
`endif
            end
          end
        end
        RESOLVE: begin
          out_sum   <= s + c;
          out_count <= count;
          out_valid <= 1'b1;
`ifdef MOA_TRUNC_FLAG_EN
          out_trunc <= forced;
`endif
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s         <= '0;
            c         <= '0;
            count     <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_multiple_operand_accumulator.sv
// Self-checking bench for multiple_operand_accumulator (N=4, MAX_OPS=16).
// Expected results are queued as {trunc, count, sum} when the closing beat is accepted.
module tb_multiple_operand_accumulator;
  localparam int N = 4;
  localparam int MAX_OPS = 16;
  localparam int OUT_W = 8;
  localparam int CW = 5;
  localparam int EW = OUT_W + CW + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic [CW-1:0]    out_count;
`ifdef MOA_TRUNC_FLAG_EN
  logic             out_trunc;
`endif

  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  multiple_operand_accumulator #(.N(N), .MAX_OPS(MAX_OPS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count)
`ifdef MOA_TRUNC_FLAG_EN
    , .out_trunc(out_trunc)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one beat, retrying while in_ready=0; valid drops 1ns after the accepting edge.
  task automatic drive_beat(input logic [N-1:0] d, input logic last, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      ok = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits on negedges until out_valid is seen.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      ok = out_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_sum !== 8'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
    n_checks++; if (out_count !== 5'd0) begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
`ifdef MOA_TRUNC_FLAG_EN
    n_checks++; if (out_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_out_trunc: got %b want 0", out_trunc); end
`endif
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_scale();
    bit ok;
    logic [EW-1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(4'd15, i == 3, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL full_accept: beat %0d not accepted, got 0 want 1", i); end
    end
    exp_q.push_back({1'b0, 5'd4, 8'd60});
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_resolve_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency_valid: got %b want 1", out_valid); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL full_sum: got %0d want %0d", out_sum, e[OUT_W-1:0]); end
    n_checks++; if (out_count !== e[OUT_W+CW-1:OUT_W]) begin n_fail++; $display("FAIL full_count: got %0d want %0d", out_count, e[OUT_W+CW-1:OUT_W]); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_valid_one_cycle: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_back_to_accum: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    bit ok;
    logic [EW-1:0] e;
    out_ready = 1'b1;
    drive_beat(4'd9, 1'b1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_accept: got 0 want 1"); end
    exp_q.push_back({1'b0, 5'd1, 8'd9});
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_c1: got %b want 0", in_ready); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_c2: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL single_sum: got %0d want %0d", out_sum, e[OUT_W-1:0]); end
    n_checks++; if (out_count !== e[OUT_W+CW-1:OUT_W]) begin n_fail++; $display("FAIL single_count: got %0d want %0d", out_count, e[OUT_W+CW-1:OUT_W]); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_c3: got %b want 1", in_ready); end
  endtask

  task automatic test_forced_close();
    bit ok;
    logic [EW-1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_beat(4'd15, 1'b0, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL forced_accept: beat %0d got 0 want 1", i); end
    end
    exp_q.push_back({1'b1, 5'd16, 8'd240});
    drive_beat(4'd3, 1'b1, ok);
    exp_q.push_back({1'b0, 5'd1, 8'd3});
    n_checks++; if (!ok) begin n_fail++; $display("FAIL forced_next_accept: got 0 want 1"); end
    // The first result was consumed while the 3 was waiting; verify the second.
    e = exp_q.pop_front();
    n_checks++; if (e[OUT_W-1:0] !== 8'd240) begin n_fail++; $display("FAIL forced_queue_order: got %0d want 240", e[OUT_W-1:0]); end
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL forced_timeout: got no out_valid want 1"); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL forced_sum2: got %0d want %0d", out_sum, e[OUT_W-1:0]); end
    n_checks++; if (out_count !== e[OUT_W+CW-1:OUT_W]) begin n_fail++; $display("FAIL forced_count2: got %0d want %0d", out_count, e[OUT_W+CW-1:OUT_W]); end
`ifdef MOA_TRUNC_FLAG_EN
    n_checks++; if (out_trunc !== e[EW-1]) begin n_fail++; $display("FAIL forced_trunc2: got %b want %b", out_trunc, e[EW-1]); end
`endif
    @(negedge clk);
  endtask

  // Holds the 16-beat result with out_ready=0 so it can be inspected before the next group.
  task automatic test_forced_hold();
    bit ok;
    logic [EW-1:0] e;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_beat(4'd15, 1'b0, ok);
    exp_q.push_back({1'b1, 5'd16, 8'd240});
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL forced_hold_timeout: got no out_valid want 1"); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL forced_sum: got %0d want %0d", out_sum, e[OUT_W-1:0]); end
    n_checks++; if (out_count !== e[OUT_W+CW-1:OUT_W]) begin n_fail++; $display("FAIL forced_count: got %0d want %0d", out_count, e[OUT_W+CW-1:OUT_W]); end
`ifdef MOA_TRUNC_FLAG_EN
    n_checks++; if (out_trunc !== e[EW-1]) begin n_fail++; $display("FAIL forced_trunc: got %b want %b", out_trunc, e[EW-1]); end
`endif
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold();
    bit ok;
    logic [EW-1:0] e;
    out_ready = 1'b0;
    drive_beat(4'd7, 1'b0, ok);
    drive_beat(4'd8, 1'b1, ok);
    exp_q.push_back({1'b0, 5'd2, 8'd15});
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hold_timeout: got no out_valid want 1"); end
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL hold_sum[%0d]: got %0d want %0d", i, out_sum, e[OUT_W-1:0]); end
      n_checks++; if (out_count !== e[OUT_W+CW-1:OUT_W]) begin n_fail++; $display("FAIL hold_count[%0d]: got %0d want %0d", i, out_count, e[OUT_W+CW-1:OUT_W]); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready); end
      in_valid = 1'b1;
      in_data  = 4'($urandom_range(0, 15));
      in_last  = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
    drive_beat(4'd1, 1'b1, ok);
    exp_q.push_back({1'b0, 5'd1, 8'd1});
    wait_valid(ok);
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL hold_ignored_sum: got %0d want %0d", out_sum, e[OUT_W-1:0]); end
    n_checks++; if (out_count !== e[OUT_W+CW-1:OUT_W]) begin n_fail++; $display("FAIL hold_ignored_count: got %0d want %0d", out_count, e[OUT_W+CW-1:OUT_W]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [EW-1:0] e;
    out_ready = 1'b1;
    drive_beat(4'd5, 1'b0, ok);
    drive_beat(4'd6, 1'b0, ok);
    drive_beat(4'd7, 1'b0, ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    n_checks++; if (out_sum !== 8'd0) begin n_fail++; $display("FAIL rstmid_sum: got %0d want 0", out_sum); end
    n_checks++; if (out_count !== 5'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", out_count); end
    rst = 1'b0;
    drive_beat(4'd1, 1'b0, ok);
    drive_beat(4'd2, 1'b1, ok);
    exp_q.push_back({1'b0, 5'd2, 8'd3});
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no out_valid want 1"); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL rstmid_sum_after: got %0d want %0d", out_sum, e[OUT_W-1:0]); end
    n_checks++; if (out_count !== e[OUT_W+CW-1:OUT_W]) begin n_fail++; $display("FAIL rstmid_count_after: got %0d want %0d", out_count, e[OUT_W+CW-1:OUT_W]); end
    // Reset while a result is held: it must be discarded.
    out_ready = 1'b0;
    @(negedge clk);
    drive_beat(4'd4, 1'b1, ok);
    wait_valid(ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_valid: got %b want 0", out_valid); end
    n_checks++; if (out_sum !== 8'd0) begin n_fail++; $display("FAIL rsthold_sum: got %0d want 0", out_sum); end
    out_ready = 1'b1;
    drive_beat(4'd2, 1'b1, ok);
    exp_q.push_back({1'b0, 5'd1, 8'd2});
    wait_valid(ok);
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[OUT_W-1:0]) begin n_fail++; $display("FAIL rsthold_next_sum: got %0d want %0d", out_sum, e[OUT_W-1:0]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit drv_done = 1'b0;
    int pushed = 0;
    int popped = 0;
    fork
      begin
        bit ok;
        int sum;
        int cnt;
        int len;
        logic [N-1:0] d;
        logic last;
        for (int g = 0; g < 25; g++) begin
          len = $urandom_range(1, 20);
          sum = 0;
          cnt = 0;
          for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d = 4'($urandom_range(0, 15));
            last = (b == len - 1);
            drive_beat(d, last, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_accept: group %0d beat %0d got 0 want 1", g, b); end
            sum += int'(d);
            cnt++;
            if (last || cnt == MAX_OPS) begin
              exp_q.push_back({!last, CW'(cnt), OUT_W'(sum)});
              pushed++;
              sum = 0;
              cnt = 0;
            end
          end
        end
        drv_done = 1'b1;
      end
      begin
        int guard = 0;
        logic [EW-1:0] e;
        while (!(drv_done && popped == pushed) && guard < 20000) begin
          @(negedge clk);
          guard++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            popped++;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_extra_result: got sum %0d with empty queue want none", out_sum);
            end else begin
              e = exp_q.pop_front();
              if (out_sum !== e[OUT_W-1:0] || out_count !== e[OUT_W+CW-1:OUT_W]) begin
                n_fail++;
                $display("FAIL rand_result %0d: got sum %0d count %0d want sum %0d count %0d",
                         popped, out_sum, out_count, e[OUT_W-1:0], e[OUT_W+CW-1:OUT_W]);
              end
`ifdef MOA_TRUNC_FLAG_EN
              n_checks++; if (out_trunc !== e[EW-1]) begin n_fail++; $display("FAIL rand_trunc %0d: got %b want %b", popped, out_trunc, e[EW-1]); end
`endif
            end
          end
        end
        n_checks++; if (guard >= 20000) begin n_fail++; $display("FAIL rand_timeout: got %0d results want %0d", popped, pushed); end
      end
    join
    out_ready = 1'b1;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d pending want 0", exp_q.size()); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_single();
    test_forced_hold();
    test_forced_close();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
